// File: rtl/sprite_scheduler.sv
// Walks the object table once per frame_start and hands each visible object
// to the sprite drawer, holding its position and bank until the drawer is done.
module sprite_scheduler #(
    parameter int NUM_OBJECTS = 8,
    parameter int OBJ_IDX_W   = 3,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 frame_start,
    output logic                 obj_rd_en,
    output logic [OBJ_IDX_W-1:0] obj_idx,
    input  logic                 obj_active,
    input  logic [9:0]           obj_x,
    input  logic [9:0]           obj_y,
    input  logic [1:0]           obj_type,
    input  logic                 draw_done,
    output logic                 plot,
    output logic [9:0]           x_pos,
    output logic [9:0]           y_pos,
    output logic [1:0]           sprite_sel,
    output logic                 busy,
    output logic                 frame_done,
    output logic [OBJ_IDX_W:0]   drawn_count,
    output logic                 frame_overrun
);

    localparam int CW = OBJ_IDX_W + 1;
    localparam logic [OBJ_IDX_W-1:0] LAST_IDX = OBJ_IDX_W'(NUM_OBJECTS - 1);
    localparam logic [10:0] SCR_W = 11'(SCREEN_W);
    localparam logic [10:0] SCR_H = 11'(SCREEN_H);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_CHECK  = 3'd2,
        S_LAUNCH = 3'd3,
        S_ARM    = 3'd4,
        S_WAIT   = 3'd5,
        S_NEXT   = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [OBJ_IDX_W-1:0]  r_obj_idx, w_obj_idx_nxt;
    logic [CW-1:0]         r_count, w_count_nxt;
    logic [CW-1:0]         r_drawn, w_drawn_nxt;
    logic [9:0]            r_x, w_x_nxt;
    logic [9:0]            r_y, w_y_nxt;
    logic [1:0]            r_sel, w_sel_nxt;
    logic                  r_rd_en, r_plot, r_busy, r_done, r_overrun;
    logic                  w_visible;
    logic                  w_last;

    // Partially off-screen objects still count as visible; the drawer clips.
    assign w_visible = obj_active && ({1'b0, obj_x} < SCR_W) && ({1'b0, obj_y} < SCR_H);
    assign w_last    = (r_obj_idx == LAST_IDX);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_state   <= S_IDLE;
            r_obj_idx <= '0;
            r_count   <= '0;
            r_drawn   <= '0;
            r_x       <= 10'd0;
            r_y       <= 10'd0;
            r_sel     <= 2'd0;
            r_rd_en   <= 1'b0;
            r_plot    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_obj_idx <= w_obj_idx_nxt;
            r_count   <= w_count_nxt;
            r_drawn   <= w_drawn_nxt;
            r_x       <= w_x_nxt;
            r_y       <= w_y_nxt;
            r_sel     <= w_sel_nxt;
            r_rd_en   <= (w_state_nxt == S_FETCH);
            r_plot    <= (w_state_nxt == S_LAUNCH);
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= (w_state_nxt == S_DONE);
            r_overrun <= frame_start && (r_state != S_IDLE);
        end
    end

    // Next-state logic; S_ARM skips draw_done since the drawer still reads idle then.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (frame_start) w_state_nxt = S_FETCH; else w_state_nxt = S_IDLE;
            S_FETCH:  w_state_nxt = S_CHECK;
            S_CHECK:  if (w_visible) w_state_nxt = S_LAUNCH; else w_state_nxt = S_NEXT;
            S_LAUNCH: w_state_nxt = S_ARM;
            S_ARM:    w_state_nxt = S_WAIT;
            S_WAIT:   if (draw_done) w_state_nxt = S_NEXT; else w_state_nxt = S_WAIT;
            S_NEXT:   if (w_last) w_state_nxt = S_DONE; else w_state_nxt = S_FETCH;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath updates; drawn_count loads on entry to S_DONE so it lines up with frame_done.
    always_comb begin
        w_obj_idx_nxt = r_obj_idx;
        w_count_nxt   = r_count;
        w_drawn_nxt   = r_drawn;
        w_x_nxt       = r_x;
        w_y_nxt       = r_y;
        w_sel_nxt     = r_sel;
        case (r_state)
            S_IDLE: begin
                if (frame_start) begin
                    w_obj_idx_nxt = '0;
                    w_count_nxt   = '0;
                end else begin
                    w_obj_idx_nxt = r_obj_idx;
                end
            end
            S_CHECK: begin
                if (w_visible) begin
                    w_x_nxt   = obj_x;
                    w_y_nxt   = obj_y;
                    w_sel_nxt = obj_type;
                end else begin
                    w_x_nxt   = r_x;
                end
            end
            S_WAIT: begin
                if (draw_done) begin
                    w_count_nxt = r_count + CW'(1);
                end else begin
                    w_count_nxt = r_count;
                end
            end
            S_NEXT: begin
                if (w_last) begin
                    w_drawn_nxt = r_count;
                end else begin
                    w_obj_idx_nxt = r_obj_idx + OBJ_IDX_W'(1);
                end
            end
            default: begin
                w_count_nxt = r_count;
            end
        endcase
    end

    assign obj_rd_en     = r_rd_en;
    assign obj_idx       = r_obj_idx;
    assign plot          = r_plot;
    assign x_pos         = r_x;
    assign y_pos         = r_y;
    assign sprite_sel    = r_sel;
    assign busy          = r_busy;
    assign frame_done    = r_done;
    assign drawn_count   = r_drawn;
    assign frame_overrun = r_overrun;

endmodule

// File: tb/tb_sprite_scheduler.sv
// Bench for sprite_scheduler: a per-cycle expectation timeline is built from
// the object table and drawer latency, and every cycle is compared against it.
module tb_sprite_scheduler;

    localparam int N    = 8;
    localparam int IW   = 3;
    localparam int MAXC = 8192;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          frame_start;
    logic          obj_rd_en;
    logic [IW-1:0] obj_idx;
    logic          obj_active = 1'b0;
    logic [9:0]    obj_x = 10'd0;
    logic [9:0]    obj_y = 10'd0;
    logic [1:0]    obj_type = 2'd0;
    logic          draw_done;
    logic          plot;
    logic [9:0]    x_pos, y_pos;
    logic [1:0]    sprite_sel;
    logic          busy, frame_done, frame_overrun;
    logic [IW:0]   drawn_count;

    sprite_scheduler dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
        .obj_rd_en(obj_rd_en), .obj_idx(obj_idx), .obj_active(obj_active),
        .obj_x(obj_x), .obj_y(obj_y), .obj_type(obj_type), .draw_done(draw_done),
        .plot(plot), .x_pos(x_pos), .y_pos(y_pos), .sprite_sel(sprite_sel),
        .busy(busy), .frame_done(frame_done), .drawn_count(drawn_count),
        .frame_overrun(frame_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Object table memory: one-cycle read latency.
    bit         tbl_act [N];
    logic [9:0] tbl_x   [N];
    logic [9:0] tbl_y   [N];
    logic [1:0] tbl_t   [N];
    always @(posedge clk) begin
        if (obj_rd_en) begin
            obj_active <= tbl_act[obj_idx];
            obj_x      <= tbl_x[obj_idx];
            obj_y      <= tbl_y[obj_idx];
            obj_type   <= tbl_t[obj_idx];
        end
    end

    // Drawer: busy for dd_len cycles after sampling plot, reset with the scheduler.
    int dd_len = 0;
    int dd_cnt = 0;
    always @(posedge clk) begin
        if (reset_n) dd_cnt <= 0;
        else if (plot) dd_cnt <= dd_len;
        else if (dd_cnt > 0) dd_cnt <= dd_cnt - 1;
    end
    assign draw_done = (dd_cnt == 0);

    bit        exp_rd [MAXC], exp_plot [MAXC], exp_hold [MAXC], exp_busy [MAXC];
    bit        exp_done [MAXC], exp_ovr [MAXC], exp_zero [MAXC];
    bit [2:0]  exp_idx [MAXC];
    bit [9:0]  exp_x [MAXC], exp_y [MAXC];
    bit [1:0]  exp_s [MAXC];
    bit [3:0]  exp_dc [MAXC];

    int n_cmp = 0, n_bad = 0;
    int mon_rd = 0, mon_plot = 0, mon_ovr = 0, mon_done = 0, mon_done_cyc = 0;
    int mon_px = 0, mon_py = 0, mon_ps = 0;
    int last_done = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0d, want %0d", name, cyc, act, expv);
        end
    endtask

    // Timeline from the rules: skipped entry = 3 cycles, drawn entry = 5 + wait cycles.
    task automatic plan_frame(input int c);
        int t, n, w;
        t = c + 1;
        n = 0;
        for (int i = 0; i < N; i++) begin
            exp_rd[t]  = 1'b1;
            exp_idx[t] = 3'(i);
            if (tbl_act[i] && tbl_x[i] < 10'd640 && tbl_y[i] < 10'd480) begin
                w = (dd_len > 1) ? dd_len : 1;
                exp_plot[t+2] = 1'b1;
                for (int k = t + 2; k <= t + 3 + w; k++) begin
                    exp_hold[k] = 1'b1;
                    exp_x[k] = tbl_x[i];
                    exp_y[k] = tbl_y[i];
                    exp_s[k] = tbl_t[i];
                end
                n++;
                t = t + 5 + w;
            end else begin
                t = t + 3;
            end
        end
        exp_done[t] = 1'b1;
        for (int k = c + 1; k <= t; k++) exp_busy[k] = 1'b1;
        for (int k = t; k < MAXC; k++) exp_dc[k] = 4'(n);
        last_done = t;
    endtask

    task automatic check_cycle();
        chk("obj_rd_en", obj_rd_en, exp_rd[cyc]);
        if (exp_rd[cyc]) chk("obj_idx", obj_idx, exp_idx[cyc]);
        chk("plot", plot, exp_plot[cyc]);
        chk("busy", busy, exp_busy[cyc]);
        chk("frame_done", frame_done, exp_done[cyc]);
        chk("frame_overrun", frame_overrun, exp_ovr[cyc]);
        chk("drawn_count", drawn_count, exp_dc[cyc]);
        if (exp_hold[cyc]) begin
            chk("x_pos_hold", x_pos, exp_x[cyc]);
            chk("y_pos_hold", y_pos, exp_y[cyc]);
            chk("sprite_sel_hold", sprite_sel, exp_s[cyc]);
        end
        if (exp_zero[cyc]) begin
            chk("reset_x_pos", x_pos, 0);
            chk("reset_y_pos", y_pos, 0);
            chk("reset_sprite_sel", sprite_sel, 0);
            chk("reset_obj_idx", obj_idx, 0);
        end
        if (obj_rd_en) mon_rd++;
        if (frame_overrun) mon_ovr++;
        if (frame_done) begin
            mon_done++;
            mon_done_cyc = cyc;
        end
        if (plot) begin
            mon_plot++;
            mon_px = x_pos;
            mon_py = y_pos;
            mon_ps = sprite_sel;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_fs();
        if (exp_busy[cyc]) exp_ovr[cyc+1] = 1'b1;
        else plan_frame(cyc);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic apply_reset();
        for (int t = cyc + 1; t < MAXC; t++) begin
            exp_rd[t] = 1'b0; exp_plot[t] = 1'b0; exp_hold[t] = 1'b0;
            exp_busy[t] = 1'b0; exp_done[t] = 1'b0; exp_ovr[t] = 1'b0;
            exp_dc[t] = 4'd0;
        end
        exp_zero[cyc+1] = 1'b1;
        reset_n = 1'b1;
        tick();
        reset_n = 1'b0;
    endtask

    task automatic wait_frame(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (frame_done) break;
            tick();
        end
        chk("frame_done_reached", frame_done, 1);
    endtask

    task automatic clear_table();
        for (int i = 0; i < N; i++) begin
            tbl_act[i] = 1'b0; tbl_x[i] = 10'd0; tbl_y[i] = 10'd0; tbl_t[i] = 2'd0;
        end
    endtask

    task automatic set_obj(input int i, input int x, input int y, input int t);
        tbl_act[i] = 1'b1; tbl_x[i] = 10'(x); tbl_y[i] = 10'(y); tbl_t[i] = 2'(t);
    endtask

    int fs_c, s_rd, s_plot, s_ovr, s_done;

    task automatic snap();
        fs_c = cyc; s_rd = mon_rd; s_plot = mon_plot; s_ovr = mon_ovr; s_done = mon_done;
    endtask

    initial begin
        reset_n     = 1'b1;
        frame_start = 1'b0;
        clear_table();
        @(posedge clk);
        #1;
        for (int t = 1; t <= 3; t++) exp_zero[t] = 1'b1;
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        chk("reset_busy", busy, 0);
        chk("reset_drawn_count", drawn_count, 0);

        // All entries inactive.
        clear_table();
        dd_len = 0;
        snap();
        pulse_fs();
        wait_frame(200);
        tick(); tick();
        chk("t1_rd_pulses", mon_rd - s_rd, 8);
        chk("t1_plots", mon_plot - s_plot, 0);
        chk("t1_pass_len", mon_done_cyc - fs_c + 1, 26);
        chk("t1_drawn", drawn_count, 0);

        // Single object with a slow drawer.
        clear_table();
        set_obj(2, 100, 50, 1);
        dd_len = 1999;
        snap();
        pulse_fs();
        wait_frame(3000);
        tick(); tick();
        chk("t2_plots", mon_plot - s_plot, 1);
        chk("t2_x", mon_px, 100);
        chk("t2_y", mon_py, 50);
        chk("t2_sel", mon_ps, 1);
        chk("t2_drawn", drawn_count, 1);

        // Eight active objects, draw_done permanently high.
        clear_table();
        for (int i = 0; i < N; i++) set_obj(i, 10 + i * 70, 20 + i * 50, i % 4);
        dd_len = 0;
        snap();
        pulse_fs();
        wait_frame(300);
        tick(); tick();
        chk("t3_plots", mon_plot - s_plot, 8);
        chk("t3_drawn", drawn_count, 8);

        // Screen boundaries.
        clear_table();
        set_obj(1, 640, 10, 3);
        set_obj(4, 5, 479, 2);
        dd_len = 2;
        snap();
        pulse_fs();
        wait_frame(300);
        tick(); tick();
        chk("t4_plots", mon_plot - s_plot, 1);
        chk("t4_y", mon_py, 479);
        chk("t4_sel", mon_ps, 2);
        chk("t4_drawn", drawn_count, 1);

        // Overrun mid-pass and in the done cycle, then immediate restart.
        clear_table();
        set_obj(0, 30, 40, 1);
        set_obj(3, 300, 200, 0);
        set_obj(7, 639, 0, 3);
        dd_len = 3;
        snap();
        pulse_fs();
        repeat (6) tick();
        pulse_fs();
        wait_frame(500);
        pulse_fs();
        pulse_fs();
        wait_frame(500);
        tick(); tick();
        chk("t5_overruns", mon_ovr - s_ovr, 2);
        chk("t5_frame_dones", mon_done - s_done, 2);
        chk("t5_drawn", drawn_count, 3);

        // Reset while waiting on the drawer, then a clean restart.
        clear_table();
        set_obj(0, 10, 20, 3);
        dd_len = 50;
        pulse_fs();
        repeat (8) tick();
        chk("t6_in_wait_busy", busy, 1);
        apply_reset();
        chk("t6_post_reset_idx", obj_idx, 0);
        chk("t6_post_reset_drawn", drawn_count, 0);
        chk("t6_post_reset_busy", busy, 0);
        tick(); tick();
        snap();
        pulse_fs();
        wait_frame(500);
        tick(); tick();
        chk("t6_plots", mon_plot - s_plot, 1);
        chk("t6_drawn", drawn_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sprite_scheduler.md
Name: sprite_scheduler

Overview:
Upstream stage of the sprite drawer. On each frame_start it walks the object table (ship, asteroids, bullets) one entry at a time. For every visible object it issues a one-cycle plot with a held top-left position and sprite bank select, then waits for the drawer's draw_done before moving to the next entry. Reports frame completion, the number of sprites drawn, and overrun.

Parameters:
NUM_OBJECTS, 8, number of object table entries (2..2**OBJ_IDX_W)
OBJ_IDX_W, 3, object index width
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-high reset (name kept per codebase; asserted = 1)
frame_start  in  1  one-cycle pulse, start a frame pass
obj_rd_en  out  1  object table read strobe; data is valid on the next cycle
obj_idx  out  OBJ_IDX_W  object table read address
obj_active  in  1  entry enabled (valid one cycle after obj_rd_en)
obj_x  in  10  entry top-left x
obj_y  in  10  entry top-left y
obj_type  in  2  sprite bank of entry
draw_done  in  1  drawer idle/finished (level, high while drawer idle)
plot  out  1  one-cycle start pulse to drawer
x_pos  out  10  held top-left x for drawer
y_pos  out  10  held top-left y for drawer
sprite_sel  out  2  held sprite ROM bank select
busy  out  1  high from accepted frame_start until frame_done
frame_done  out  1  one-cycle pulse at end of pass
drawn_count  out  OBJ_IDX_W+1  sprites drawn in last completed pass
frame_overrun  out  1  one-cycle pulse: frame_start arrived while busy

Behaviour:
- Reset (reset_n=1 at posedge): state S_IDLE. All outputs 0: obj_idx, x_pos, y_pos, sprite_sel, drawn_count, plot, obj_rd_en, busy, frame_done, frame_overrun. Internal draw counter is 0.
- S_IDLE: on frame_start, set obj_idx=0 and clear the internal count, then go to S_FETCH. busy is 1 from the next cycle.
- S_FETCH: obj_rd_en=1 for one cycle, then go to S_CHECK.
- S_CHECK: obj_* inputs are valid this cycle.
  - Skip the object if obj_active=0, or obj_x>=SCREEN_W, or obj_y>=SCREEN_H. Skipped objects go to S_NEXT.
  - Partially off-screen objects are drawn; clipping belongs downstream.
  - Otherwise latch obj_x→x_pos, obj_y→y_pos, obj_type→sprite_sel, then go to S_LAUNCH.
- S_LAUNCH: plot=1 for exactly one cycle, then go to S_ARM.
- S_ARM: one-cycle guard. draw_done is ignored here because the drawer still shows done in the cycle plot is sampled. Then go to S_WAIT.
- S_WAIT: stay until draw_done=1. When it is, increment the count and go to S_NEXT. No timeout.
- x_pos, y_pos and sprite_sel must not change from S_CHECK latch through S_WAIT exit. The drawer reads them combinationally for every pixel.
- S_NEXT:
  - If obj_idx==NUM_OBJECTS-1: go to S_DONE.
  - Otherwise obj_idx+1 and go to S_FETCH.
  - obj_idx never wraps inside a pass.
- S_DONE: frame_done=1 for one cycle. drawn_count is loaded from the internal count in the same cycle. busy drops the next cycle. Return to S_IDLE; obj_idx holds its last value.
- frame_start in any state other than S_IDLE: ignored, and frame_overrun=1 for one cycle. The pass continues unaffected. A frame_start in the S_DONE cycle also counts as overrun.
- frame_start in S_IDLE the cycle after S_DONE: accepted normally.
- Reset mid-pass: return to S_IDLE immediately with the reset values above. Any in-flight plot is abandoned; the drawer is reset by the same signal.
- Minimum cost per pass: 3 cycles per skipped object, plus 1 for S_DONE, plus 1 cycle of frame_start acceptance.
- Drawn object cost: 5 cycles plus the drawer time.

Test Plan:
- All 8 entries inactive, frame_start → 8 obj_rd_en pulses, no plot, frame_done 26 cycles after frame_start, drawn_count=0.
- Entry 2 active at (100,50) type 1, drawer model asserts draw_done 2000 cycles after plot → a single plot with x_pos=100, y_pos=50, sprite_sel=1 held until draw_done; drawn_count=1.
- draw_done tied high throughout → the plot/S_ARM guard still advances exactly one object per plot; 8 active entries give 8 plots, drawn_count=8.
- Entries at x=640 and y=479 → first skipped (no plot), second drawn (plot with y_pos=479).
- frame_start re-pulsed mid-pass and in the S_DONE cycle → frame_overrun pulses each time, pass unchanged, single frame_done.
- reset_n asserted during S_WAIT → next cycle all outputs 0, state idle; a following frame_start restarts from obj_idx=0.
